// File: rtl/cte_pkg.sv
// Shared types and constants for the colour-transform-engine stream scheduler.
package cte_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic MODE_YUV2RGB = 1'b0;
    localparam logic MODE_RGB2YUV = 1'b1;

    // Y groups are U,Y,V,Y bytes giving two RGB pixels; R groups are two pixels giving four YUV bytes.
    localparam logic [2:0] Y_IN_N  = 3'd4;
    localparam logic [2:0] Y_OUT_N = 3'd2;
    localparam logic [2:0] R_IN_N  = 3'd2;
    localparam logic [2:0] R_OUT_N = 3'd4;

    function automatic logic [2:0] in_target(input logic mode);
        return (mode == MODE_RGB2YUV) ? R_IN_N : Y_IN_N;
    endfunction

    function automatic logic [2:0] out_target(input logic mode);
        return (mode == MODE_RGB2YUV) ? R_OUT_N : Y_OUT_N;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between requester Y and requester R.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_arb_en,
    input  logic i_req_y,
    input  logic i_req_r,
    output logic o_gnt_y,
    output logic o_gnt_r
);

    logic r_last_r;   // 1 = R won the most recent grant

    // Grant combinationally; on a tie the side that did not win last time goes first.
    always_comb begin
        // NOTE: every combinationally driven signal gets a default first, so no path can infer a latch.
        o_gnt_y = 1'b0;
        o_gnt_r = 1'b0;
        if (i_arb_en) begin
            if (i_req_y && (!i_req_r || r_last_r)) begin
                o_gnt_y = 1'b1;
            end else if (i_req_r) begin
                o_gnt_r = 1'b1;
            end
        end
    end

    // Remember the last winner; reset favours Y on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_last_r <= 1'b1;
        end else if (o_gnt_y) begin
            r_last_r <= 1'b0;
        end else if (o_gnt_r) begin
            r_last_r <= 1'b1;
        end
    end

endmodule

// File: rtl/cte_stream_sched.sv
// Schedules one shared colour-transform engine between a YUV byte stream and an RGB pixel stream,
// one group at a time, with result demux and a watchdog on stalled groups.
module cte_stream_sched
    import cte_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             y_valid,
    input  logic [7:0]       y_data,
    output logic             y_ready,
    input  logic             r_valid,
    input  logic [23:0]      r_data,
    output logic             r_ready,
    output logic             cte_op_mode,
    output logic             cte_in_en,
    output logic [7:0]       cte_yuv_in,
    output logic [23:0]      cte_rgb_in,
    input  logic             cte_busy,
    input  logic             cte_out_valid,
    input  logic [23:0]      cte_rgb_out,
    input  logic [7:0]       cte_yuv_out,
    output logic [23:0]      rgb_res,
    output logic             rgb_res_vld,
    output logic [7:0]       yuv_res,
    output logic             yuv_res_vld,
    output logic [CNT_W-1:0] grp_done,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_pulse
);

    localparam int WD_W = $clog2(TIMEOUT);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_op_mode;
    logic [2:0]        r_in_cnt;
    logic [2:0]        r_out_cnt;
    logic [WD_W-1:0]   r_wd;
    logic [CNT_W-1:0]  r_grp_done;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [23:0]       r_rgb_res;
    logic              r_rgb_vld;
    logic [7:0]        r_yuv_res;
    logic              r_yuv_vld;

    logic w_gnt_y;
    logic w_gnt_r;
    logic w_grant;
    logic w_active;
    logic w_req_valid;
    logic w_beat;
    logic w_res;
    logic w_in_last;
    logic w_done;
    logic w_abort;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (reset),
        .i_arb_en (enable && (r_state == S_IDLE)),
        .i_req_y  (y_valid),
        .i_req_r  (r_valid),
        .o_gnt_y  (w_gnt_y),
        .o_gnt_r  (w_gnt_r)
    );

    assign w_grant     = w_gnt_y || w_gnt_r;
    assign w_active    = (r_state != S_IDLE);
    assign w_req_valid = (r_op_mode == MODE_RGB2YUV) ? r_valid : y_valid;
    assign w_done      = (r_state == S_DRAIN) && (r_out_cnt == out_target(r_op_mode));
    // A completed group wins over a watchdog expiry in the same cycle.
    assign w_abort     = w_active && !w_done && (r_wd == WD_W'(TIMEOUT - 1));
    assign w_beat      = (r_state == S_FEED) && w_req_valid && !cte_busy && !w_abort;
    assign w_res       = w_active && cte_out_valid;
    assign w_in_last   = w_beat && ((r_in_cnt + 3'd1) == in_target(r_op_mode));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: grant in IDLE, feed the group, drain its results, or abort on watchdog.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next_state = S_FEED;
            S_FEED:  if (w_abort) w_next_state = S_IDLE;
                     else if (w_in_last) w_next_state = S_DRAIN;
            S_DRAIN: if (w_done || w_abort) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Group bookkeeping: latched mode, beat/result counters and the stall watchdog.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_mode <= MODE_YUV2RGB;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_wd      <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_grant) begin
                r_op_mode <= w_gnt_r ? MODE_RGB2YUV : MODE_YUV2RGB;
            end
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_wd      <= '0;
        end else begin
            if (w_beat) begin
                r_in_cnt <= r_in_cnt + 3'd1;
            end
            if (w_res && (r_out_cnt != 3'd7)) begin
                r_out_cnt <= r_out_cnt + 3'd1;
            end
            if (w_beat || w_res) begin
                r_wd <= '0;
            end else if (!w_abort) begin
                r_wd <= r_wd + WD_W'(1);
            end
        end
    end

    // Status counters: completed groups wrap, watchdog aborts saturate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grp_done <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_done) begin
                r_grp_done <= r_grp_done + CNT_W'(1);
            end
            if (w_abort && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    // Register engine results one cycle late and route them by the group's mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rgb_res <= '0;
            r_rgb_vld <= 1'b0;
            r_yuv_res <= '0;
            r_yuv_vld <= 1'b0;
        end else begin
            r_rgb_vld <= w_res && (r_op_mode == MODE_YUV2RGB);
            r_yuv_vld <= w_res && (r_op_mode == MODE_RGB2YUV);
            if (w_res && (r_op_mode == MODE_YUV2RGB)) begin
                r_rgb_res <= cte_rgb_out;
            end
            if (w_res && (r_op_mode == MODE_RGB2YUV)) begin
                r_yuv_res <= cte_yuv_out;
            end
        end
    end

    assign y_ready     = w_beat && (r_op_mode == MODE_YUV2RGB);
    assign r_ready     = w_beat && (r_op_mode == MODE_RGB2YUV);
    assign cte_in_en   = w_beat;
    assign cte_op_mode = r_op_mode;
    assign cte_yuv_in  = (w_beat && (r_op_mode == MODE_YUV2RGB)) ? y_data : 8'h00;
    assign cte_rgb_in  = (w_beat && (r_op_mode == MODE_RGB2YUV)) ? r_data : 24'h000000;
    assign rgb_res     = r_rgb_res;
    assign rgb_res_vld = r_rgb_vld;
    assign yuv_res     = r_yuv_res;
    assign yuv_res_vld = r_yuv_vld;
    assign grp_done    = r_grp_done;
    assign err_cnt     = r_err_cnt;
    assign err_pulse   = w_abort;

endmodule

// File: tb/tb_cte_stream_sched.sv
// Directed bench for cte_stream_sched with a small behavioural engine model.
module tb_cte_stream_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        y_valid;
    logic [7:0]  y_data;
    logic        y_ready;
    logic        r_valid;
    logic [23:0] r_data;
    logic        r_ready;
    logic        cte_op_mode;
    logic        cte_in_en;
    logic [7:0]  cte_yuv_in;
    logic [23:0] cte_rgb_in;
    logic        cte_busy;
    logic        cte_out_valid;
    logic [23:0] cte_rgb_out;
    logic [7:0]  cte_yuv_out;
    logic [23:0] rgb_res;
    logic        rgb_res_vld;
    logic [7:0]  yuv_res;
    logic        yuv_res_vld;
    logic [15:0] grp_done;
    logic [15:0] err_cnt;
    logic        err_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    // Engine model state: pending results, Y-beat parity, R result index, result budget (-1 = unlimited).
    int         m_pend   = 0;
    int         m_yb     = 0;
    int         m_ridx   = 0;
    int         m_budget = -1;
    logic [7:0] m_last_y = 8'h00;

    always #5 clk = ~clk;

    cte_stream_sched #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .y_valid       (y_valid),
        .y_data        (y_data),
        .y_ready       (y_ready),
        .r_valid       (r_valid),
        .r_data        (r_data),
        .r_ready       (r_ready),
        .cte_op_mode   (cte_op_mode),
        .cte_in_en     (cte_in_en),
        .cte_yuv_in    (cte_yuv_in),
        .cte_rgb_in    (cte_rgb_in),
        .cte_busy      (cte_busy),
        .cte_out_valid (cte_out_valid),
        .cte_rgb_out   (cte_rgb_out),
        .cte_yuv_out   (cte_yuv_out),
        .rgb_res       (rgb_res),
        .rgb_res_vld   (rgb_res_vld),
        .yuv_res       (yuv_res),
        .yuv_res_vld   (yuv_res_vld),
        .grp_done      (grp_done),
        .err_cnt       (err_cnt),
        .err_pulse     (err_pulse)
    );

    // Engine model: every second Y byte yields one grey RGB pixel {Y,Y,Y}; each RGB pixel yields two
    // YUV bytes numbered A0, A1, ... Results come out one per cycle, starting the cycle after the beat.
    initial begin : cte_model
        cte_out_valid = 1'b0;
        cte_rgb_out   = 24'h0;
        cte_yuv_out   = 8'h0;
        forever begin
            @(negedge clk);
            if (cte_in_en === 1'b1) begin
                if (cte_op_mode === 1'b0) begin
                    if (m_yb % 2 == 1) begin
                        m_last_y = cte_yuv_in;
                        m_pend++;
                    end
                    m_yb++;
                end else begin
                    m_pend += 2;
                end
            end
            @(posedge clk);
            #1;
            if (m_pend > 0 && m_budget != 0) begin
                cte_out_valid = 1'b1;
                cte_rgb_out   = {3{m_last_y}};
                cte_yuv_out   = 8'hA0 + 8'(m_ridx);
                if (cte_op_mode === 1'b1) m_ridx++;
                m_pend--;
                if (m_budget > 0) m_budget--;
            end else begin
                cte_out_valid = 1'b0;
            end
        end
    end

    task automatic model_clear();
        m_pend   = 0;
        m_yb     = 0;
        m_ridx   = 0;
        m_budget = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({y_ready, r_ready, cte_in_en, cte_op_mode, rgb_res_vld, yuv_res_vld, err_pulse} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {y_ready, r_ready, cte_in_en, cte_op_mode, rgb_res_vld, yuv_res_vld, err_pulse});
        end
        n_cmp++;
        if ({grp_done, err_cnt} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_counters: got grp_done=%0d err_cnt=%0d want 0/0", grp_done, err_cnt);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_y_only();
        logic [15:0] base;
        int nb, first_c, last_c, mode_bad, data_bad, n_rgb, rgb_bad;
        nb = 0; first_c = 0; last_c = 0; mode_bad = 0; data_bad = 0; n_rgb = 0; rgb_bad = 0;
        model_clear();
        base = grp_done;
        enable = 1'b1; y_valid = 1'b1; y_data = 8'h80;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cte_in_en) begin
                if (nb == 0) first_c = c;
                last_c = c;
                nb++;
                if (cte_yuv_in !== 8'h80) data_bad++;
                if (cte_op_mode !== 1'b0) mode_bad++;
            end
            if (rgb_res_vld) begin
                n_rgb++;
                if (rgb_res !== 24'h808080) rgb_bad++;
            end
            @(posedge clk);
            #1;
            if (nb == 4) y_valid = 1'b0;
        end
        n_cmp++;
        if (nb !== 4 || (last_c - first_c) !== 3) begin
            n_bad++;
            $display("FAIL y_beats: got %0d beats over %0d cycles want 4 over 4", nb, last_c - first_c + 1);
        end
        n_cmp++;
        if (mode_bad !== 0 || data_bad !== 0) begin
            n_bad++;
            $display("FAIL y_feed: got mode_bad=%0d data_bad=%0d want 0/0", mode_bad, data_bad);
        end
        n_cmp++;
        if (n_rgb !== 2 || rgb_bad !== 0) begin
            n_bad++;
            $display("FAIL y_results: got %0d pulses (%0d wrong) want 2 of 808080", n_rgb, rgb_bad);
        end
        n_cmp++;
        if (grp_done !== base + 16'd1) begin
            n_bad++;
            $display("FAIL y_grp_done: got %0d want %0d", grp_done, base + 16'd1);
        end
    endtask

    task automatic test_r_only();
        logic [15:0] base;
        logic [23:0] pix [2];
        int idx, busy_viol, data_bad, n_yuv, yuv_bad, mode_bad, y_leak;
        logic started;
        pix[0] = 24'hFF0000; pix[1] = 24'h0000FF;
        idx = 0; busy_viol = 0; data_bad = 0; n_yuv = 0; yuv_bad = 0; mode_bad = 0; y_leak = 0;
        started = 1'b0;
        model_clear();
        base = grp_done;
        enable = 1'b1; y_valid = 1'b0; r_valid = 1'b1; r_data = pix[0]; cte_busy = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (r_ready && cte_busy) busy_viol++;
            if (y_ready) y_leak++;
            if (cte_in_en) begin
                started = 1'b1;
                if (idx < 2 && cte_rgb_in !== pix[idx]) data_bad++;
                idx++;
            end
            if (started && cte_op_mode !== 1'b1) mode_bad++;
            if (yuv_res_vld) begin
                if (yuv_res !== 8'hA0 + 8'(n_yuv)) yuv_bad++;
                n_yuv++;
            end
            @(posedge clk);
            #1;
            cte_busy = ~cte_busy;
            if (idx < 2) r_data = pix[idx];
            else r_valid = 1'b0;
        end
        cte_busy = 1'b0;
        n_cmp++;
        if (busy_viol !== 0 || y_leak !== 0) begin
            n_bad++;
            $display("FAIL r_busy: got r_ready-with-busy=%0d y_ready=%0d want 0/0", busy_viol, y_leak);
        end
        n_cmp++;
        if (idx !== 2 || data_bad !== 0) begin
            n_bad++;
            $display("FAIL r_feed: got %0d beats (%0d wrong) want 2", idx, data_bad);
        end
        n_cmp++;
        if (n_yuv !== 4 || yuv_bad !== 0 || yuv_res !== 8'hA3) begin
            n_bad++;
            $display("FAIL r_results: got %0d pulses (%0d wrong), held %h want 4, held a3", n_yuv, yuv_bad, yuv_res);
        end
        n_cmp++;
        if (mode_bad !== 0 || grp_done !== base + 16'd1) begin
            n_bad++;
            $display("FAIL r_mode_done: got mode_bad=%0d grp_done=%0d want 0/%0d", mode_bad, grp_done, base + 16'd1);
        end
    endtask

    task automatic test_contention();
        logic [15:0] base, prev_done;
        logic [3:0]  modes;
        logic [23:0] first_rgb;
        logic        need;
        int ng, yi, n_rgb, n_yuv;
        modes = 4'b0; first_rgb = 24'h0; need = 1'b1; ng = 0; yi = 0; n_rgb = 0; n_yuv = 0;
        model_clear();
        base = grp_done; prev_done = grp_done;
        enable = 1'b1; y_valid = 1'b1; r_valid = 1'b1; y_data = 8'h10; r_data = 24'h123456;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (grp_done != prev_done) begin
                need = 1'b1;
                prev_done = grp_done;
            end
            if (cte_in_en && need) begin
                if (ng < 4) modes[3 - ng] = cte_op_mode;
                ng++;
                need = 1'b0;
            end
            if (y_ready) yi = (yi + 1) % 4;
            if (rgb_res_vld) begin
                if (n_rgb == 0) first_rgb = rgb_res;
                n_rgb++;
            end
            if (yuv_res_vld) n_yuv++;
            if (grp_done == base + 16'd4) break;
            @(posedge clk);
            #1;
            y_data = 8'((yi + 1) * 16);
            if (ng >= 4) enable = 1'b0;
        end
        @(posedge clk);
        #1;
        y_valid = 1'b0; r_valid = 1'b0; enable = 1'b1;
        n_cmp++;
        if (modes !== 4'b0101 || ng !== 4) begin
            n_bad++;
            $display("FAIL arb_order: got modes=%b groups=%0d want 0101 (Y,R,Y,R) groups=4", modes, ng);
        end
        n_cmp++;
        if (n_rgb !== 4 || n_yuv !== 8 || first_rgb !== 24'h202020) begin
            n_bad++;
            $display("FAIL arb_results: got rgb=%0d yuv=%0d first=%h want 4/8/202020", n_rgb, n_yuv, first_rgb);
        end
        n_cmp++;
        if (grp_done !== base + 16'd4) begin
            n_bad++;
            $display("FAIL arb_grp_done: got %0d want %0d", grp_done, base + 16'd4);
        end
    endtask

    task automatic test_watchdog();
        logic [15:0] base, ebase;
        int nb, last_act, err_c, n_err, n_rgb;
        nb = 0; last_act = 0; err_c = 0; n_err = 0; n_rgb = 0;
        model_clear();
        m_budget = 1;
        base = grp_done; ebase = err_cnt;
        enable = 1'b1; y_valid = 1'b1; y_data = 8'h80; r_valid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cte_in_en) nb++;
            if (cte_in_en || cte_out_valid) last_act = c;
            if (err_pulse) begin
                n_err++;
                err_c = c;
            end
            @(posedge clk);
            #1;
            if (nb == 4) y_valid = 1'b0;
        end
        n_cmp++;
        if (n_err !== 1 || (err_c - last_act) !== 16) begin
            n_bad++;
            $display("FAIL wd_pulse: got %0d pulses, %0d cycles after activity want 1, 16", n_err, err_c - last_act);
        end
        n_cmp++;
        if (err_cnt !== ebase + 16'd1 || grp_done !== base) begin
            n_bad++;
            $display("FAIL wd_counters: got err_cnt=%0d grp_done=%0d want %0d/%0d", err_cnt, grp_done, ebase + 16'd1, base);
        end
        // Recovery: a normal Y group right after the abort must complete.
        model_clear();
        nb = 0;
        y_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cte_in_en) nb++;
            if (rgb_res_vld) n_rgb++;
            @(posedge clk);
            #1;
            if (nb == 4) y_valid = 1'b0;
        end
        n_cmp++;
        if (nb !== 4 || n_rgb !== 2 || grp_done !== base + 16'd1 || err_cnt !== ebase + 16'd1) begin
            n_bad++;
            $display("FAIL wd_recover: got beats=%0d rgb=%0d grp_done=%0d err_cnt=%0d want 4/2/%0d/%0d",
                     nb, n_rgb, grp_done, err_cnt, base + 16'd1, ebase + 16'd1);
        end
    endtask

    task automatic test_enable_drop();
        logic [15:0] base;
        int nb, n_rgb, post_ready;
        nb = 0; n_rgb = 0; post_ready = 0;
        model_clear();
        base = grp_done;
        enable = 1'b1; y_valid = 1'b1; y_data = 8'h80; r_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (cte_in_en) nb++;
            if (rgb_res_vld) n_rgb++;
            if (grp_done == base + 16'd1 && (y_ready || r_ready || cte_in_en)) post_ready++;
            @(posedge clk);
            #1;
            if (nb == 2) enable = 1'b0;
            if (grp_done == base + 16'd1) r_valid = 1'b1;
        end
        n_cmp++;
        if (nb !== 4 || n_rgb !== 2 || grp_done !== base + 16'd1) begin
            n_bad++;
            $display("FAIL en_finish: got beats=%0d rgb=%0d grp_done=%0d want 4/2/%0d", nb, n_rgb, grp_done, base + 16'd1);
        end
        n_cmp++;
        if (post_ready !== 0) begin
            n_bad++;
            $display("FAIL en_no_grant: got %0d accepts while disabled want 0", post_ready);
        end
        y_valid = 1'b0; r_valid = 1'b0; enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic got;
        logic first_mode;
        logic tie_ok;
        got = 1'b0; first_mode = 1'b1; tie_ok = 1'b0;
        model_clear();
        enable = 1'b1; y_valid = 1'b0; r_valid = 1'b1; r_data = 24'h00FF00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cte_in_en) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL rst_start: got no R beat within 10 cycles want one");
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({y_ready, r_ready, cte_in_en, cte_op_mode, rgb_res_vld, yuv_res_vld, err_pulse} !== 7'b0 ||
            cte_yuv_in !== 8'h0 || cte_rgb_in !== 24'h0) begin
            n_bad++;
            $display("FAIL rst_mid_flags: got %b yuv_in=%h rgb_in=%h want zeros",
                     {y_ready, r_ready, cte_in_en, cte_op_mode, rgb_res_vld, yuv_res_vld, err_pulse},
                     cte_yuv_in, cte_rgb_in);
        end
        n_cmp++;
        if (grp_done !== 16'h0 || err_cnt !== 16'h0 || rgb_res !== 24'h0 || yuv_res !== 8'h0) begin
            n_bad++;
            $display("FAIL rst_mid_regs: got grp_done=%0d err_cnt=%0d rgb=%h yuv=%h want zeros",
                     grp_done, err_cnt, rgb_res, yuv_res);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        y_valid = 1'b1; y_data = 8'h80; r_valid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cte_in_en) begin
                got = 1'b1;
                first_mode = cte_op_mode;
                tie_ok = y_ready && !r_ready;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!got || first_mode !== 1'b0 || !tie_ok) begin
            n_bad++;
            $display("FAIL rst_tie: got beat=%b mode=%b y_first=%b want 1/0/1", got, first_mode, tie_ok);
        end
        @(posedge clk);
        #1;
        y_valid = 1'b0; r_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0;
        y_valid = 1'b0; y_data = 8'h0;
        r_valid = 1'b0; r_data = 24'h0;
        cte_busy = 1'b0;
        test_reset();
        test_y_only();
        test_r_only();
        test_contention();
        test_watchdog();
        test_enable_drop();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
